rans_interleave_sched: RTL and testbench

- Sequencer that shares one multi-cycle rANS encode core among N_LANES interleaved coder states.
- Accepts a single symbol stream and assigns symbols round-robin to lanes.
- Per symbol: fetches freq/cum_freq from the frequency table, byte-renormalizes the lane state onto the output byte stream, then dispatches the encode (state' = ((state/freq) << RESOLUTION) + state%freq + cum_freq) to the shared core.
- On flush, emits every lane's final state and reinitializes.

---
 rtl/rans_interleave_sched.sv | 202 ++++++++++++++++++++
 tb/tb_rans_interleave_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rans_interleave_sched.sv
// Shares one multi-cycle rANS encode core among N_LANES interleaved coder states:
// round-robin lane assignment, table lookup, byte renormalization, encode dispatch and flush.
module rans_interleave_sched #(
  parameter int RESOLUTION = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int N_LANES = 2,
  parameter int STATE_WIDTH = 32,
  parameter logic [STATE_WIDTH-1:0] RANS_L = STATE_WIDTH'(1 << 23),
  localparam int LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SYMBOL_WIDTH-1:0] s_symbol,
  input  logic                    flush,
  output logic                    tbl_rd_en,
  output logic [SYMBOL_WIDTH-1:0] tbl_addr,
  input  logic [RESOLUTION:0]     tbl_freq,
  input  logic [RESOLUTION-1:0]   tbl_cum,
  output logic                    core_req,
  output logic [STATE_WIDTH-1:0]  core_state,
  output logic [RESOLUTION:0]     core_freq,
  output logic [RESOLUTION-1:0]   core_cum,
  input  logic                    core_ack,
  input  logic [STATE_WIDTH-1:0]  core_result,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic                    byte_last,
  output logic [LANE_W-1:0]       lane_idx,
  output logic                    busy,
  output logic                    err_freq0,
  output logic [2:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer keeps valid and its payload stable until that edge (core_req/core_ack alike).

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_CAPTURE, ST_RENORM, ST_ENC_REQ, ST_ENC_WAIT, ST_FLUSH
  } state_t;

  localparam int XW = STATE_WIDTH + RESOLUTION + 1;
  localparam int STATE_BYTES = STATE_WIDTH / 8;
  localparam int CNT_W = (STATE_BYTES > 1) ? $clog2(STATE_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STATE_BYTES - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
  localparam logic [XW-1:0] XMAX_BASE = XW'(RANS_L >> RESOLUTION) << 8;

  state_t                 state_q;
  logic [STATE_WIDTH-1:0] lanes [N_LANES];
  logic [STATE_WIDTH-1:0] x_q;
  logic [XW-1:0]          x_max_q;
  logic [LANE_W-1:0]      flush_lane;
  logic [CNT_W-1:0]       byte_cnt;

  logic [XW-1:0]          x_max_c;
  logic [STATE_WIDTH-1:0] cur_lane;
  logic [STATE_WIDTH-1:0] x_shift;
  logic [LANE_W-1:0]      nxt_lane;
  logic [CNT_W-1:0]       nxt_cnt;
  logic [7:0]             nxt_byte;
  logic                   nxt_last;
  logic                   flush_done;
  logic [LANE_W-1:0]      lane_nxt;

  assign core_state = x_q;
  assign dbg_state  = state_q;

  always_comb begin
    x_max_c  = XMAX_BASE * XW'(tbl_freq);
    cur_lane = lanes[lane_idx];
    x_shift  = x_q >> 8;
    if (byte_cnt == LAST_CNT) begin
      nxt_cnt  = '0;
      nxt_lane = flush_lane - 1'b1;
    end else begin
      nxt_cnt  = byte_cnt + 1'b1;
      nxt_lane = flush_lane;
    end
    nxt_byte   = 8'(lanes[nxt_lane] >> {nxt_cnt, 3'b000});
    nxt_last   = (nxt_lane == '0) && (nxt_cnt == LAST_CNT);
    flush_done = (flush_lane == '0) && (byte_cnt == LAST_CNT);
    lane_nxt   = (N_LANES == 1) ? '0 : lane_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < N_LANES; i++) lanes[i] <= RANS_L;
      lane_idx   <= '0;
      x_q        <= '0;
      x_max_q    <= '0;
      flush_lane <= '0;
      byte_cnt   <= '0;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
      tbl_rd_en  <= 1'b0;
      tbl_addr   <= '0;
      core_req   <= 1'b0;
      core_freq  <= '0;
      core_cum   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_last  <= 1'b0;
      err_freq0  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            tbl_addr  <= s_symbol;
            tbl_rd_en <= 1'b1;
            s_ready   <= 1'b0;
            busy      <= 1'b1;
            state_q   <= ST_FETCH;
          end else if (flush) begin
            flush_lane <= LAST_LANE;
            byte_cnt   <= '0;
            byte_valid <= 1'b1;
            byte_data  <= lanes[LAST_LANE][7:0];
            byte_last  <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b1;
            state_q    <= ST_FLUSH;
          end
        end
        ST_FETCH: begin
          tbl_rd_en <= 1'b0;
          state_q   <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          core_freq <= tbl_freq;
          core_cum  <= tbl_cum;
          x_max_q   <= x_max_c;
          x_q       <= cur_lane;
          if (tbl_freq == '0) begin
            err_freq0 <= 1'b1;
            s_ready   <= 1'b1;
            busy      <= 1'b0;
            state_q   <= ST_IDLE;
          end else begin
            // Present the first renorm byte right away so RENORM only tracks handshakes.
            if (XW'(cur_lane) >= x_max_c) begin
              byte_valid <= 1'b1;
              byte_data  <= cur_lane[7:0];
            end
            state_q <= ST_RENORM;
          end
        end
        ST_RENORM: begin
          if (byte_valid) begin
            if (byte_ready) begin
              x_q <= x_shift;
              if (XW'(x_shift) >= x_max_q) begin
                byte_data <= x_shift[7:0];
              end else begin
                byte_valid <= 1'b0;
              end
            end
          end else begin
            state_q <= ST_ENC_REQ;
          end
        end
        ST_ENC_REQ: begin
          core_req <= 1'b1;
          state_q  <= ST_ENC_WAIT;
        end
        ST_ENC_WAIT: begin
          if (core_ack) begin
            core_req        <= 1'b0;
            lanes[lane_idx] <= core_result;
            lane_idx        <= lane_nxt;
            s_ready         <= 1'b1;
            busy            <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (byte_ready) begin
            if (flush_done) begin
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
              for (int i = 0; i < N_LANES; i++) lanes[i] <= RANS_L;
              lane_idx <= '0;
              s_ready  <= 1'b1;
              busy     <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              flush_lane <= nxt_lane;
              byte_cnt   <= nxt_cnt;
              byte_data  <= nxt_byte;
              byte_last  <= nxt_last;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_interleave_sched.sv
// Bench for rans_interleave_sched: directed cases plus a randomized run checked against an
// interleaved rANS encoder/decoder model written directly from the coding rules.
module tb_rans_interleave_sched;

  localparam int N = 2;
  localparam int RES = 10;
  localparam longint RANS_L = 64'd1 << 23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_symbol = '0;
  logic        flush = 1'b0;
  logic        tbl_rd_en;
  logic [7:0]  tbl_addr;
  logic [10:0] tbl_freq = '0;
  logic [9:0]  tbl_cum = '0;
  logic        core_req;
  logic [31:0] core_state;
  logic [10:0] core_freq;
  logic [9:0]  core_cum;
  logic        core_ack = 1'b0;
  logic [31:0] core_result = '0;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        lane_idx;
  logic        busy;
  logic        err_freq0;
  logic [2:0]  dbg_state;

  rans_interleave_sched dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_symbol(s_symbol),
    .flush(flush), .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_freq(tbl_freq),
    .tbl_cum(tbl_cum), .core_req(core_req), .core_state(core_state), .core_freq(core_freq),
    .core_cum(core_cum), .core_ack(core_ack), .core_result(core_result),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .lane_idx(lane_idx), .busy(busy), .err_freq0(err_freq0),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model and scoreboard
  int          ftab [256];
  int          ctab [256];
  longint      m_lane [N];
  int          m_idx;
  logic        m_err;
  logic [8:0]  exp_q[$];
  logic [52:0] core_exp_q[$];
  logic [7:0]  got_seg[$];
  int          sym_hist[$];

  function automatic longint enc(input longint x, input longint f, input longint c);
    return (((x / f) << RES) + (x % f) + c) & 64'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < N; l++) m_lane[l] = RANS_L;
    m_idx = 0;
    m_err = 1'b0;
    exp_q.delete();
    core_exp_q.delete();
  endtask

  task automatic model_accept(input int sym);
    longint x, xmax;
    int f, c;
    f = ftab[sym];
    c = ctab[sym];
    if (f == 0) begin
      m_err = 1'b1;
      return;
    end
    x = m_lane[m_idx];
    xmax = ((RANS_L >> RES) << 8) * f;
    while (x >= xmax) begin
      exp_q.push_back({1'b0, 8'(x)});
      x = x >> 8;
    end
    core_exp_q.push_back({32'(x), 11'(f), 10'(c)});
    m_lane[m_idx] = enc(x, f, c);
    m_idx = (m_idx + 1) % N;
  endtask

  task automatic model_flush();
    for (int l = N - 1; l >= 0; l--)
      for (int b = 0; b < 4; b++)
        exp_q.push_back({(l == 0 && b == 3), 8'(m_lane[l] >> (8 * b))});
    for (int l = 0; l < N; l++) m_lane[l] = RANS_L;
    m_idx = 0;
  endtask

  // environment: table memory, encode core, byte sink (all act on the falling edge)
  int     ready_mode = 0;
  logic   core_rand = 1'b0;
  logic   core_hold = 1'b0;
  logic   late_ack = 1'b0;
  int     core_wait = 0;
  int     core_cnt = 0;
  int     byte_cnt = 0;
  logic [31:0] last_core_state = '0;

  always @(negedge clk) begin
    if (tbl_rd_en) begin
      tbl_freq = 11'(ftab[tbl_addr]);
      tbl_cum  = 10'(ctab[tbl_addr]);
    end
    if (core_hold) begin
      core_ack = late_ack;
    end else if (core_req) begin
      if (core_wait == 0) begin
        core_ack = 1'b1;
        core_result = 32'(enc(core_state, core_freq, core_cum));
        last_core_state = core_state;
        core_cnt++;
        if (core_exp_q.size() == 0) check_eq("core_extra", 1, 0);
        else check_eq("core_operands", {core_state, core_freq, core_cum}, core_exp_q.pop_front());
      end else begin
        core_wait--;
        core_ack = 1'b0;
      end
    end else begin
      core_ack = 1'b0;
      core_wait = core_rand ? $urandom_range(0, 3) : 0;
    end
    case (ready_mode)
      0: byte_ready = 1'b1;
      1: byte_ready = ($urandom_range(0, 3) != 0);
      default: byte_ready = 1'b0;
    endcase
    if (byte_valid && byte_ready) begin
      byte_cnt++;
      got_seg.push_back(byte_data);
      if (exp_q.size() == 0) check_eq("byte_extra", 1, 0);
      else check_eq("byte", {byte_last, byte_data}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic send_sym(input int sym);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_symbol = 8'(sym);
    n = 0;
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check_eq("accept_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    model_accept(sym);
  endtask

  task automatic do_flush();
    int n;
    wait_idle(n);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    wait_idle(n);
    check_eq("flush_busy", busy, 0);
  endtask

  task automatic decode_check();
    longint st [N];
    longint x;
    int pos, s, slot, l;
    pos = got_seg.size() - 1;
    for (int k = 0; k < N; k++) begin
      x = 0;
      for (int b = 0; b < 4; b++)
        if (pos >= 0) begin
          x = (x << 8) | longint'(got_seg[pos]);
          pos--;
        end
      st[k] = x;
    end
    for (int i = sym_hist.size() - 1; i >= 0; i--) begin
      l = i % N;
      x = st[l];
      slot = int'(x & 1023);
      s = -1;
      for (int k = 0; k < 256; k++)
        if (ftab[k] != 0 && slot >= ctab[k] && slot < ctab[k] + ftab[k]) s = k;
      check_eq("decode_sym", 64'(s), 64'(sym_hist[i]));
      if (s < 0) return;
      x = longint'(ftab[s]) * (x >> RES) + slot - ctab[s];
      while (x < RANS_L && pos >= 0) begin
        x = (x << 8) | longint'(got_seg[pos]);
        pos--;
      end
      st[l] = x;
    end
    check_eq("decode_bytes_left", 64'(pos + 1), 0);
    for (int k = 0; k < N; k++) check_eq("decode_final_state", st[k], RANS_L);
  endtask

  initial begin
    int n, b0, c0;
    logic [7:0] held;
    for (int k = 0; k < 256; k++) begin
      ftab[k] = 0;
      ctab[k] = 0;
    end
    ftab[0] = 512; ctab[0] = 0;
    ftab[1] = 1;   ctab[1] = 5;
    ftab[2] = 0;   ctab[2] = 0;

    // reset state
    do_reset();
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outputs", {tbl_rd_en, core_req, byte_valid, byte_last, err_freq0}, 0);
    check_eq("rst_lane_idx", lane_idx, 0);

    // freq=512: no renorm, minimum latency
    b0 = byte_cnt;
    send_sym(0);
    wait_idle(n);
    check_eq("min_latency", n, 5);
    check_eq("sym512_core_state", last_core_state, 32'h0080_0000);
    check_eq("sym512_no_bytes", byte_cnt - b0, 0);
    check_eq("sym512_lane_idx", lane_idx, 1);

    // freq=1 on fresh lane 1: one renorm byte
    b0 = byte_cnt;
    send_sym(1);
    wait_idle(n);
    check_eq("sym1_one_byte", byte_cnt - b0, 1);
    check_eq("sym1_core_state", last_core_state, 32'h0000_8000);
    check_eq("sym1_lane_idx", lane_idx, 0);
    b0 = byte_cnt;
    do_flush();
    check_eq("flush_after_syms_bytes", byte_cnt - b0, 8);
    check_eq("flush_lane_idx", lane_idx, 0);

    // reset then flush
    do_reset();
    b0 = byte_cnt;
    do_flush();
    check_eq("flush_init_bytes", byte_cnt - b0, 8);

    // downstream stall during renorm
    do_reset();
    ready_mode = 2;
    send_sym(1);
    n = 0;
    while (!byte_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_byte_valid", byte_valid, 1);
    held = byte_data;
    check_eq("stall_byte_value", held, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_hold", {byte_valid, byte_data, core_req, s_ready}, {1'b1, held, 1'b0, 1'b0});
    end
    ready_mode = 0;
    wait_idle(n);
    check_eq("stall_done_lane_idx", lane_idx, 1);

    // freq=0 lookup: sticky error, nothing emitted
    do_reset();
    b0 = byte_cnt;
    c0 = core_cnt;
    send_sym(2);
    wait_idle(n);
    check_eq("freq0_err", err_freq0, m_err);
    check_eq("freq0_no_bytes", byte_cnt - b0, 0);
    check_eq("freq0_no_core", core_cnt - c0, 0);
    check_eq("freq0_lane_idx", lane_idx, 0);
    send_sym(0);
    wait_idle(n);
    check_eq("freq0_sticky", err_freq0, 1);
    check_eq("after_freq0_lane_idx", lane_idx, 1);

    // reset while waiting on the core, then a late ack
    core_hold = 1'b1;
    send_sym(0);
    n = 0;
    while (!core_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq("core_req_held", core_req, 1);
    do_reset();
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    core_hold = 1'b0;
    check_eq("midrst_idle", {s_ready, busy, core_req, byte_valid}, 4'b1000);
    check_eq("midrst_err_cleared", err_freq0, 0);
    check_eq("midrst_lane_idx", lane_idx, 0);
    b0 = byte_cnt;
    do_flush();
    check_eq("midrst_flush_bytes", byte_cnt - b0, 8);

    // randomized run: skewed table over 16 symbols summing to 2^RES
    do_reset();
    for (int k = 0; k < 256; k++) begin
      ftab[k] = 0;
      ctab[k] = 0;
    end
    for (int k = 0; k < 16; k++) ftab[k] = 1;
    for (int k = 0; k < 1024 - 16; k++) begin
      n = $urandom_range(0, $urandom_range(0, 15));
      ftab[n]++;
    end
    for (int k = 1; k < 16; k++) ctab[k] = ctab[k-1] + ftab[k-1];
    core_rand = 1'b1;
    ready_mode = 1;
    for (int seg = 0; seg < 4; seg++) begin
      got_seg.delete();
      sym_hist.delete();
      for (int i = 0; i < 400; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        n = $urandom_range(0, 15);
        send_sym(n);
        sym_hist.push_back(n);
      end
      do_flush();
      decode_check();
    end

    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("core_q_drained", core_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
